// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer: data width and launch FSM states.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } launch_state_t;

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Synchronous FIFO with a combinational head read and an occupancy counter 0..DEPTH.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign full    = (r_count == FULL_COUNT);
  assign empty   = (r_count == '0);

  // Storage is not reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (rd_en) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      case ({wr_en, rd_en})
        2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter: one-cycle txStart launches gated by txBusy.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  dataReady,
  input  logic                  txBusy,
  output logic                  txStart,
  output logic [DATA_WIDTH-1:0] txData,
  output logic                  bufEmpty,
  output logic                  bufFull,
  output logic                  overflow,
  output logic                  o_dbg_state
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = DEPTH[ADDR_WIDTH:0];

  // Producer side: level strobe, no backpressure; a write is taken whenever a slot
  // is free at the edge (including the slot freed by a pop in the same cycle),
  // otherwise the byte is dropped and overflow latches.
  launch_state_t         r_state;
  logic                  r_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_overflow;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_head;
  logic [ADDR_WIDTH:0]   w_count;

  assign w_pop  = (r_state == ST_IDLE) && !w_empty && !txBusy;
  assign w_push = dataReady && (!w_full || w_pop);

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (w_push),
    .wr_data(data),
    .rd_en  (w_pop),
    .rd_data(w_head),
    .count  (w_count),
    .full   (w_full),
    .empty  (w_empty)
  );

  // HOLD gives the transmitter one cycle to raise txBusy after a launch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (dataReady && !w_push) r_overflow <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_tx_data  <= w_head;
            r_tx_start <= 1'b1;
            r_state    <= ST_HOLD;
          end else begin
            r_tx_start <= 1'b0;
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign txStart     = r_tx_start;
  assign txData      = r_tx_data;
  assign overflow    = r_overflow;
  assign bufEmpty    = (w_count == '0);
  assign bufFull     = (w_count == FULL_COUNT);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: reset, single byte, burst, busy stall, full/overflow, push+pop at full.
module tb_uart_tx_buffer;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       dataReady;
  logic       txBusy;
  logic       txStart;
  logic [7:0] txData;
  logic       bufEmpty;
  logic       bufFull;
  logic       overflow;
  logic       o_dbg_state;

  int n_cmp;
  int n_err;

  uart_tx_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .dataReady  (dataReady),
    .txBusy     (txBusy),
    .txStart    (txStart),
    .txData     (txData),
    .bufEmpty   (bufEmpty),
    .bufFull    (bufFull),
    .overflow   (overflow),
    .o_dbg_state(o_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    data      = 8'h55;
    dataReady = 1'b1;
    txBusy    = 1'b0;

    // Reset held for two edges with a write strobe active
    tick();
    tick();
    chk("rst_txStart", txStart, 0);
    chk("rst_txData", txData, 8'h00);
    chk("rst_bufEmpty", bufEmpty, 1);
    chk("rst_bufFull", bufFull, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_state", o_dbg_state, 0);
    rst_n     = 1'b1;
    dataReady = 1'b0;
    tick();
    chk("rst_nothing_queued", bufEmpty, 1);
    chk("rst_no_launch", txStart, 0);

    // Single byte
    data      = 8'h41;
    dataReady = 1'b1;
    tick();
    dataReady = 1'b0;
    chk("single_queued", bufEmpty, 0);
    chk("single_no_early_start", txStart, 0);
    tick();
    chk("single_start", txStart, 1);
    chk("single_data", txData, 8'h41);
    chk("single_empty", bufEmpty, 1);
    chk("single_state_hold", o_dbg_state, 1);
    tick();
    chk("single_pulse_end", txStart, 0);
    chk("single_data_held", txData, 8'h41);
    tick();
    chk("single_data_held2", txData, 8'h41);
    chk("single_no_repeat", txStart, 0);

    // Burst of 10 bytes: launch k (1-based) happens at cycle 2k
    begin
      int pulses;
      pulses = 0;
      for (int c = 1; c <= 24; c++) begin
        if (c <= 10) begin
          data      = 8'h40 + 8'(c);
          dataReady = 1'b1;
        end else begin
          dataReady = 1'b0;
        end
        tick();
        chk("burst_start", txStart, ((c % 2) == 0 && c <= 20) ? 1 : 0);
        if (txStart) begin
          pulses++;
          chk("burst_data", txData, 8'h40 + 8'(c / 2));
        end
      end
      chk("burst_pulses", pulses, 10);
      chk("burst_overflow", overflow, 0);
      chk("burst_empty", bufEmpty, 1);
    end

    // Busy stall: three bytes queue up, nothing launches for 8 cycles
    txBusy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 3) begin
        data      = 8'h41 + 8'(c);
        dataReady = 1'b1;
      end else begin
        dataReady = 1'b0;
      end
      tick();
      chk("stall_no_start", txStart, 0);
    end
    chk("stall_not_empty", bufEmpty, 0);
    chk("stall_data_kept", txData, 8'h4A);
    txBusy = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk("stall_start", txStart, ((c % 2) == 1 && c <= 5) ? 1 : 0);
      if (txStart) chk("stall_data", txData, 8'h41 + 8'((c - 1) / 2));
    end
    chk("stall_drained", bufEmpty, 1);

    // Fill with 17 bytes while busy; the 17th is dropped
    txBusy = 1'b1;
    for (int c = 0; c < 17; c++) begin
      data      = 8'(c);
      dataReady = 1'b1;
      tick();
      if (c == 14) chk("fill_not_full_15", bufFull, 0);
      if (c == 15) begin
        chk("fill_full_16", bufFull, 1);
        chk("fill_no_overflow_16", overflow, 0);
      end
    end
    chk("fill_overflow", overflow, 1);
    chk("fill_still_full", bufFull, 1);
    chk("fill_no_start", txStart, 0);

    // Push and pop together at full: 0xAA is accepted, count stays 16
    txBusy    = 1'b0;
    data      = 8'hAA;
    dataReady = 1'b1;
    tick();
    dataReady = 1'b0;
    chk("pp_start", txStart, 1);
    chk("pp_data", txData, 8'h00);
    chk("pp_still_full", bufFull, 1);
    for (int c = 2; c <= 36; c++) begin
      tick();
      chk("drain_start", txStart, ((c % 2) == 1 && c <= 33) ? 1 : 0);
      if (txStart) chk("drain_data", txData, (c == 33) ? 8'hAA : 8'((c - 1) / 2));
    end
    chk("drain_empty", bufEmpty, 1);
    chk("drain_overflow_sticky", overflow, 1);
    chk("drain_last_data", txData, 8'hAA);

    // Reset clears the sticky flag and data register
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_overflow", overflow, 0);
    chk("rst2_txData", txData, 8'h00);
    chk("rst2_empty", bufEmpty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Byte FIFO between a byte producer and a UART transmitter.
- Accepts one byte per clock while dataReady is high.
- Feeds queued bytes to the transmitter in order: issues a one-cycle txStart pulse with the byte on txData whenever the transmitter reports not busy.
- Decouples bursty producers (command parsers, loopback paths) from the slow serial transmitter.

Parameters:
- DATA_WIDTH, 8: width of data, txData and each FIFO entry.
- DEPTH, 16: number of FIFO entries; must be a power of two and at least 2.
- ADDR_WIDTH, log2(DEPTH) = 4: pointer width. Derived parameter, not overridden by users.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- data  in  DATA_WIDTH  byte to enqueue.
- dataReady  in  1  level write strobe; each cycle it is high, data is enqueued.
- txBusy  in  1  transmitter busy flag; high while a frame is being shifted out.
- txStart  out  1  registered one-cycle pulse telling the transmitter to send txData.
- txData  out  DATA_WIDTH  registered byte; valid with txStart, held until the next launch.
- bufEmpty  out  1  FIFO holds 0 entries (combinational from count).
- bufFull  out  1  FIFO holds DEPTH entries (combinational from count).
- overflow  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n low at a rising edge):
  - Read pointer, write pointer and count all 0.
  - txStart=0, txData=0, overflow=0, FSM returns to IDLE.
  - bufEmpty=1, bufFull=0.
  - Applies mid-transfer too: queued bytes are discarded.
- Write:
  - Condition: dataReady=1 and (count<DEPTH, or a pop occurs in the same cycle).
  - Stores data at the write pointer; pointer wraps modulo DEPTH.
  - dataReady=1 with the FIFO full and no pop in that cycle: byte dropped, overflow set to 1 until reset.
- Launch FSM, two states:
  - IDLE: if count>0 and txBusy=0, pop the head entry. On that edge, txData<=head and txStart<=1; go to HOLD. Otherwise txStart<=0 and stay in IDLE.
  - HOLD: txStart<=0; ignore txBusy for this cycle, because the transmitter needs one cycle to raise busy. Go to IDLE unconditionally.
- Throughput and latency:
  - Maximum one launch per 2 cycles.
  - A byte written at edge E into an empty FIFO, with txBusy=0 during the following cycle, gives txStart=1 and txData=byte after edge E+1.
- Ordering: strict FIFO. Every accepted byte is launched exactly once; no duplicates.
- Simultaneous push and pop: both occur and count is unchanged. Legal at count=DEPTH, so a full FIFO accepts a write in the cycle it pops. At count=0 the new byte is not popped in the same cycle; it launches no earlier than the next edge.
- Count range is 0..DEPTH, so the count register is ADDR_WIDTH+1 bits.
- txBusy=1 while in IDLE stalls launches indefinitely. The FIFO keeps accepting writes up to full.
- txData changes only at a launch edge, or to 0 on reset.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_WIDTH=8.
  - Launch FSM state enum (IDLE, HOLD).
- One natural sub-module: sync_fifo (parameters DATA_WIDTH, DEPTH).
  - Ports: clk, rst_n, wr_en, wr_data, rd_en, rd_data, count, full, empty.
  - Read data available combinationally from the head entry.
- The top level holds the launch FSM, output registers and the overflow flag.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with dataReady=1 and data=0x55 -> txStart=0, txData=0x00, bufEmpty=1, overflow=0; nothing enqueued.
- Single byte, txBusy=0: dataReady=1 with data=0x41 for one cycle -> one txStart pulse with txData=0x41 on the next edge, then bufEmpty=1; txData stays 0x41 afterwards.
- Burst, txBusy=0: 10 consecutive cycles of dataReady=1 with data 0x41..0x4A -> txStart pulses every other cycle with txData 0x41..0x4A in order; exactly 10 pulses; no overflow.
- Busy stall:
  - Enqueue 0x41..0x43 while txBusy=1 for 8 cycles -> no txStart; count reaches 3.
  - Drop txBusy -> 0x41, 0x42, 0x43 launch in order, 2 cycles apart.
- Full and overflow:
  - With txBusy=1, write 17 bytes 0x00..0x10 -> bufFull=1 after 16; 0x10 dropped; overflow=1.
  - Release txBusy -> bytes 0x00..0x0F launch; overflow remains 1 until reset.
- Simultaneous push/pop at full: FIFO full, txBusy falls, dataReady=1 with data=0xAA on the pop cycle -> 0xAA accepted, count stays 16, 0xAA is the last byte launched.
